// File: rtl/control_sync.sv
// control_sync: brings a quasi-static JTAG control word into the clk domain,
// accepting a word only after it has been seen unchanged for STABLE_CYCLES+1 samples.
module control_sync #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] control_async,
    input  logic             hold,
    output logic [WIDTH-1:0] control,
    output logic             control_valid,
    output logic             control_changed,
    output logic [7:0]       change_count
);
    typedef enum logic {UNLOCKED, LOCKED} state_e;

    localparam logic [7:0] S = 8'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q, control_q, sync_last;
    logic [7:0]                        cnt_q, cnt_d, count_q;
    logic                              changed_q, stable, accept;
    state_e                            state_q;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign stable    = sync_last == prev_q;
    assign cnt_d     = !stable ? 8'd0 : (cnt_q == S ? S : cnt_q + 8'd1);
    // the first accept after reset is unconditional on value, so an all-zero word still locks
    assign accept    = cnt_q == S && stable && !hold && (state_q == UNLOCKED || sync_last != control_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            control_q <= '0;
            changed_q <= 1'b0;
            count_q   <= '0;
            state_q   <= UNLOCKED;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], control_async};
            prev_q    <= sync_last;
            cnt_q     <= cnt_d;
            changed_q <= accept;
            if (accept) begin
                control_q <= sync_last;
                count_q   <= count_q + 8'd1;
                state_q   <= LOCKED;
            end
        end
    end

    assign control         = control_q;
    assign control_valid   = state_q == LOCKED;
    assign control_changed = changed_q;
    assign change_count    = count_q;
endmodule

// File: tb/tb_control_sync.sv
// tb_control_sync: directed stimulus with a queue-based acceptance model checked every cycle.
module tb_control_sync;
    localparam int W  = 8;
    localparam int SS = 2;
    localparam int S  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hold = 1'b0;
    logic [W-1:0] control_async = '0;
    logic [W-1:0] control;
    logic         control_valid, control_changed;
    logic [7:0]   change_count;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    bit done = 1'b0;

    control_sync #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .control_async(control_async), .hold(hold),
        .control(control), .control_valid(control_valid),
        .control_changed(control_changed), .change_count(change_count)
    );

    always #5 clk = ~clk;

    // model: a word is accepted once the last S+2 synchronized samples (incl. prev) agree
    logic [W-1:0] pipe[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_control;
    logic         m_valid, m_changed;
    logic [7:0]   m_count;

    task automatic model_reset();
        pipe.delete();
        repeat (SS) pipe.push_back('0);
        hist.delete();
        hist.push_back('0);
        m_control = '0;
        m_valid   = 1'b0;
        m_changed = 1'b0;
        m_count   = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] s;
        bit eq, acc;
        s = pipe.pop_front();
        pipe.push_back(control_async);
        hist.push_back(s);
        if (hist.size() > S + 2) void'(hist.pop_front());
        eq = hist.size() == S + 2;
        foreach (hist[k]) if (hist[k] != s) eq = 1'b0;
        acc = eq && !hold && (!m_valid || s != m_control);
        m_changed = acc;
        if (acc) begin
            m_control = s;
            m_valid   = 1'b1;
            m_count   = m_count + 8'd1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!done) begin
            check("model_control", control, m_control);
            check("model_valid", control_valid, m_valid);
            check("model_changed", control_changed, m_changed);
            check("model_count", change_count, m_count);
            if (control_changed === 1'b1) pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0, n;
        logic [W-1:0] skew[3];
        skew = '{8'h7C, 8'h7E, 8'hFE};
        tick(3);
        check("rst_control", control, 8'h00);
        check("rst_valid", control_valid, 1'b0);
        check("rst_count", change_count, 8'h00);
        rst = 1'b0;
        tick(4);
        check("lock0_not_yet", control_valid, 1'b0);
        tick(1);
        check("lock0_valid", control_valid, 1'b1);
        check("lock0_control", control, 8'h00);
        check("lock0_pulse", control_changed, 1'b1);
        check("lock0_count", change_count, 8'd1);
        tick(5);
        control_async = 8'hA5;
        tick(7);
        check("a5_edge6_control", control, 8'h00);
        tick(1);
        check("a5_edge7_control", control, 8'hA5);
        check("a5_edge7_pulse", control_changed, 1'b1);
        check("a5_count", change_count, 8'd2);
        tick(1);
        check("a5_pulse_single", control_changed, 1'b0);
        tick(5);
        p0 = pulses;
        control_async = 8'h5A;
        tick(3);
        control_async = 8'hA5;
        tick(15);
        check("glitch_control", control, 8'hA5);
        check("glitch_count", change_count, 8'd2);
        check("glitch_pulses", pulses - p0, 0);
        hold = 1'b1;
        control_async = 8'h3C;
        tick(20);
        check("hold_control", control, 8'hA5);
        check("hold_count", change_count, 8'd2);
        hold = 1'b0;
        tick(1);
        check("unhold_control", control, 8'h3C);
        check("unhold_pulse", control_changed, 1'b1);
        check("unhold_count", change_count, 8'd3);
        tick(1);
        check("unhold_pulse_single", control_changed, 1'b0);
        tick(3);
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            control_async = skew[i];
            tick(1);
        end
        control_async = 8'hC3;
        tick(12);
        check("skew_control", control, 8'hC3);
        check("skew_count", change_count, 8'd4);
        check("skew_pulses", pulses - p0, 1);
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            control_async = i[0] ? 8'h11 : 8'h22;
            tick(9);
        end
        check("wrap_count", change_count, 8'd4);
        check("wrap_pulses", pulses - p0, 256);
        check("wrap_control", control, 8'h11);
        control_async = 8'h77;
        tick(6);
        check("pending_control", control, 8'h11);
        #2 rst = 1'b1;
        #1;
        check("midrst_control", control, 8'h00);
        check("midrst_valid", control_valid, 1'b0);
        check("midrst_pulse", control_changed, 1'b0);
        check("midrst_count", change_count, 8'h00);
        tick(1);
        rst = 1'b0;
        n = 0;
        while (control_valid !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check("reacq_edges", n, 8);
        check("reacq_control", control, 8'h77);
        check("reacq_count", change_count, 8'd1);
        check("reacq_pulse", control_changed, 1'b1);
        tick(2);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/control_sync.md
CONTROL_SYNC -- requirements
Module: control_sync

Interface
REQ-001 Parameter WIDTH, default 8, width of the control word received from the JTAG register.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops; legal range 2..4.
REQ-003 Parameter STABLE_CYCLES (S), default 4, consecutive equal synchronized samples required before acceptance; legal range 1..255.
REQ-004 clk  input  1  system clock (clk_50mhz domain).
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 control_async  input  WIDTH  control word from the JTAG-to-register block (DRCK domain, quasi-static).
REQ-007 hold  input  1  clk-domain freeze; high suppresses acceptance of new values.
REQ-008 control  output  WIDTH  filtered control word, clk domain.
REQ-009 control_valid  output  1  high once the first value has been accepted after reset.
REQ-010 control_changed  output  1  one-cycle pulse coincident with each update of control.
REQ-011 change_count  output  8  number of accepted updates, modulo 256.

Function
REQ-012 Each bit of control_async SHALL pass through a SYNC_STAGES-deep flop chain; sync_q is the last stage.
REQ-013 A register prev SHALL load sync_q on every clk edge.
REQ-014 Stability counter cnt (8 bits): on each edge, cnt SHALL clear to 0 if sync_q != prev, else increment, saturating at S.
REQ-015 Accept condition SHALL be: cnt == S, sync_q == prev, hold == 0, and (control_valid == 0 or sync_q != control).
REQ-016 On an edge where accept holds: control <= sync_q, control_valid <= 1, control_changed <= 1, change_count <= change_count + 1 (wrapping 255 -> 0).
REQ-017 control_changed SHALL be 0 on every edge where accept does not hold; it is never high for two consecutive cycles.
REQ-018 State machine: UNLOCKED (control_valid=0) -> LOCKED on first accept; LOCKED has no exit except reset.
REQ-019 Latency: if the first synchronizer flop captures a new value V at edge A and control_async holds V thereafter, control SHALL equal V after edge A + SYNC_STAGES + S + 1 (A+7 at defaults), with control_changed high for the cycle following that edge.
REQ-020 A value that reverts before cnt reaches S SHALL never appear on control and SHALL not pulse control_changed.
REQ-021 A stable value equal to the current control SHALL not re-trigger control_changed or change_count.
REQ-022 hold high: cnt keeps counting; a value that becomes eligible during hold SHALL be accepted on the first edge with hold low, if still stable.
REQ-023 Bits changing on different cycles (skew across DRCK/clk) SHALL restart cnt on each change; only the final settled word is accepted.
REQ-024 control SHALL never present a word that was not observed on sync_q for S+1 consecutive samples.

Reset
REQ-025 rst high SHALL immediately clear sync chain, prev, cnt, control, control_valid, control_changed, change_count to 0, including mid-acceptance.
REQ-026 After rst deasserts, the block SHALL re-acquire per REQ-015 with control_valid=0 until the first accept, even if the input equals 0.

Verification
REQ-027 Reset release, control_async=8'h00 held -> control_valid rises with control=8'h00, one control_changed pulse, change_count=1.
REQ-028 Locked at 8'h00, step control_async to 8'hA5 -> control=8'hA5 exactly 7 edges after the first sync flop captures it, one pulse, change_count=2.
REQ-029 Locked at 8'hA5, glitch to 8'h5A for 3 clk cycles then back -> control stays 8'hA5, no pulse, change_count unchanged.
REQ-030 hold=1, step input to 8'h3C, keep hold 20 cycles -> no update; drop hold -> control=8'h3C one edge later, single pulse.
REQ-031 Drive 256 distinct accepted updates -> change_count wraps 255 -> 0 with a pulse on each update.
REQ-032 Assert rst for one cycle while cnt=S-1 on a pending value -> all outputs 0 immediately; value re-acquired per REQ-026.
